// File: rtl/rf_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared constants for the register-file writeback arbiter:
//               register addressing, requester ids, default data width and
//               a register-address to one-hot mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

  // Register file addressing
  localparam int REG_ADDR_W    = 5;
  localparam int NREG          = 32;

  // Requester ids, used as indices into req/gnt vectors
  localparam int REQ_ALU       = 0;
  localparam int REQ_LSU       = 1;

  // Default register / write-data width
  localparam int DEFAULT_WIDTH = 32;

  // Expands a register address into a one-hot register mask
  function automatic logic [NREG-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NREG-1:0] mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_wb_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input round-robin arbiter. The grant is combinational;
//               the pointer remembers which input was granted last and only
//               moves when the granted request is actually accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // Index of the input granted on the last accepted transfer. Resetting to
  // input 1 makes input 0 (ALU) the preferred winner of the first contest.
  logic r_last;

  // Grant: lone requester wins; on contention the input not granted last wins
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = r_last ? 2'b01 : 2'b10;
    end
  end

  // Pointer moves only on an accepted transfer so a stalled winner keeps priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (accept) begin
      r_last <= gnt[1];
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Shares the register file write port between the ALU and LSU
//               writeback paths with valid/ready handshakes and round-robin
//               arbitration, drives we3/a3/wd3 from a registered output stage
//               and keeps a busy scoreboard of registers with pending writes.
//               Optional macro RF_WB_STATS_EN adds saturating stall counters
//               (alu_stall_cnt / lsu_stall_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // ALU writeback request
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [WIDTH-1:0]      alu_data,
  output logic                  alu_ready,
  // LSU writeback request
  input  logic                  lsu_valid,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [WIDTH-1:0]      lsu_data,
  output logic                  lsu_ready,
  // Issue of an instruction that will write a register
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  output logic [NREG-1:0]       busy,
`ifdef RF_WB_STATS_EN
  output logic [CNT_W-1:0]      alu_stall_cnt,
  output logic [CNT_W-1:0]      lsu_stall_cnt,
`endif
  // Register file write port
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_a3,
  output logic [WIDTH-1:0]      rf_wd
);

  logic [1:0]            w_req;
  logic [1:0]            w_gnt;
  logic                  w_xfer;
  logic [REG_ADDR_W-1:0] w_rd;
  logic [WIDTH-1:0]      w_data;

  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_a3;
  logic [WIDTH-1:0]      r_wd;

  logic [NREG-1:0]       r_busy;
  logic [NREG-1:0]       w_busy_set;
  logic [NREG-1:0]       w_busy_clr;
  logic [NREG-1:0]       w_busy_nxt;

  assign w_req[REQ_ALU] = alu_valid;
  assign w_req[REQ_LSU] = lsu_valid;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (w_req),
    .accept (w_xfer),
    .gnt    (w_gnt)
  );

  // Grants are only ever raised for valid requests, so ready == grant
  assign alu_ready = w_gnt[REQ_ALU];
  assign lsu_ready = w_gnt[REQ_LSU];
  assign w_xfer    = |w_gnt;

  // Select the winning requester's destination and data
  always_comb begin
    w_rd   = alu_rd;
    w_data = alu_data;
    if (w_gnt[REQ_LSU]) begin
      w_rd   = lsu_rd;
      w_data = lsu_data;
    end
  end

  // Output stage: capture the transfer; writes to x0 are accepted but never enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we <= 1'b0;
      r_a3 <= '0;
      r_wd <= '0;
    end else if (w_xfer) begin
      r_we <= (w_rd != '0);
      r_a3 <= w_rd;
      r_wd <= w_data;
    end else begin
      r_we <= 1'b0;
    end
  end

  assign rf_we = r_we;
  assign rf_a3 = r_a3;
  assign rf_wd = r_wd;

  // Scoreboard next state: the write-enable cycle clears, an issue sets, and
  // set is applied last so a new producer wins over a retiring one. x0 never busy.
  always_comb begin
    w_busy_set = iss_valid ? reg_onehot(iss_rd) : '0;
    w_busy_clr = r_we      ? reg_onehot(r_a3)   : '0;
    w_busy_nxt = (r_busy & ~w_busy_clr) | w_busy_set;
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy = r_busy;

`ifdef RF_WB_STATS_EN
  logic [CNT_W-1:0] r_alu_stall;
  logic [CNT_W-1:0] r_lsu_stall;

  // Saturating counts of cycles each requester spent waiting for a grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_stall <= '0;
      r_lsu_stall <= '0;
    end else begin
      if (alu_valid && !alu_ready && (r_alu_stall != '1)) begin
        r_alu_stall <= r_alu_stall + 1'b1;
      end
      if (lsu_valid && !lsu_ready && (r_lsu_stall != '1)) begin
        r_lsu_stall <= r_lsu_stall + 1'b1;
      end
    end
  end

  assign alu_stall_cnt = r_alu_stall;
  assign lsu_stall_cnt = r_lsu_stall;
`endif

endmodule : rf_wb_arbiter
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_arbiter
// Description : Self-checking bench for rf_wb_arbiter: table of handshake
//               vectors with expected readies, a queue of expected write-port
//               values and an independent busy model, plus hand-written
//               reset-mid-operation and stall-counter sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             alu_valid, lsu_valid, iss_valid;
  logic [4:0]       alu_rd, lsu_rd, iss_rd;
  logic [WIDTH-1:0] alu_data, lsu_data;
  logic             alu_ready, lsu_ready;
  logic [31:0]      busy;
  logic             rf_we;
  logic [4:0]       rf_a3;
  logic [WIDTH-1:0] rf_wd;
`ifdef RF_WB_STATS_EN
  logic [CNT_W-1:0] alu_stall_cnt, lsu_stall_cnt;
`endif

  always #5 clk = ~clk;

  rf_wb_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .busy      (busy),
`ifdef RF_WB_STATS_EN
    .alu_stall_cnt (alu_stall_cnt),
    .lsu_stall_cnt (lsu_stall_cnt),
`endif
    .rf_we     (rf_we),
    .rf_a3     (rf_a3),
    .rf_wd     (rf_wd)
  );

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        iv;
    logic [4:0]  ird;
    logic        ear;
    logic        elr;
  } vec_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
  } wr_t;

  int   total = 0;
  int   bad   = 0;
  wr_t  exp_q[$];
  vec_t vecs[$];

  // Bench model of the write port, scoreboard and stall counters
  logic             m_we;
  logic [4:0]       m_a3;
  logic [31:0]      m_wd;
  logic [31:0]      m_busy;
  logic [CNT_W-1:0] m_ac, m_lc;

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                              input logic iv, input logic [4:0] ird,
                              input logic ear, input logic elr);
    vec_t v;
    v.av = av; v.ard = ard; v.adata = adata;
    v.lv = lv; v.lrd = lrd; v.ldata = ldata;
    v.iv = iv; v.ird = ird; v.ear = ear; v.elr = elr;
    return v;
  endfunction

  function automatic logic [31:0] bit_of(input logic [4:0] a);
    logic [31:0] one;
    one = 32'd1;
    return one << a;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_we = 1'b0; m_a3 = '0; m_wd = '0; m_busy = '0; m_ac = '0; m_lc = '0;
    exp_q.delete();
  endtask

  // Apply one vector for one clock: check readies, push expected write, check after edge
  task automatic run_vec(input vec_t v, input string tag);
    logic [31:0] nb;
    wr_t nxt, got;
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.adata;
    lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ldata;
    iss_valid = v.iv; iss_rd = v.ird;
    #1;
    chk({tag, "_alu_ready"}, 64'(alu_ready), 64'(v.ear));
    chk({tag, "_lsu_ready"}, 64'(lsu_ready), 64'(v.elr));
    nb = m_busy & ~(m_we ? bit_of(m_a3) : 32'd0);
    if (v.iv) nb = nb | bit_of(v.ird);
    nb[0] = 1'b0;
    if (v.av && v.ear)      nxt = '{we: (v.ard != 0), a3: v.ard, wd: v.adata};
    else if (v.lv && v.elr) nxt = '{we: (v.lrd != 0), a3: v.lrd, wd: v.ldata};
    else                    nxt = '{we: 1'b0, a3: m_a3, wd: m_wd};
    exp_q.push_back(nxt);
    if (v.av && !v.ear && m_ac != '1) m_ac = m_ac + 1'b1;
    if (v.lv && !v.elr && m_lc != '1) m_lc = m_lc + 1'b1;
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk({tag, "_rf_we"}, 64'(rf_we), 64'(got.we));
    if (got.we) begin
      chk({tag, "_rf_a3"}, 64'(rf_a3), 64'(got.a3));
      chk({tag, "_rf_wd"}, 64'(rf_wd), 64'(got.wd));
    end
    m_we = got.we; m_a3 = got.a3; m_wd = got.wd;
    m_busy = nb;
    chk({tag, "_busy"}, 64'(busy), 64'(m_busy));
`ifdef RF_WB_STATS_EN
    chk({tag, "_alu_stall"}, 64'(alu_stall_cnt), 64'(m_ac));
    chk({tag, "_lsu_stall"}, 64'(lsu_stall_cnt), 64'(m_lc));
`endif
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
    iss_valid = 0; iss_rd = '0;
  endtask

  // Assert reset asynchronously mid-cycle and check the cleared state at once
  task automatic async_reset_check(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_rf_we"}, 64'(rf_we), 64'd0);
    chk({tag, "_rf_a3"}, 64'(rf_a3), 64'd0);
    chk({tag, "_rf_wd"}, 64'(rf_wd), 64'd0);
    chk({tag, "_busy"},  64'(busy),  64'd0);
`ifdef RF_WB_STATS_EN
    chk({tag, "_alu_stall"}, 64'(alu_stall_cnt), 64'd0);
    chk({tag, "_lsu_stall"}, 64'(lsu_stall_cnt), 64'd0);
`endif
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Directed table: ALU single write, RR alternation, scoreboard, x0
    vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0, 1, 0)); // 0 ALU rd5
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0)); // 1 idle, rf_we drops
    vecs.push_back(mk(0, 0, 0,            1, 2, 32'h22220000, 0, 0, 0, 1)); // 2 LSU alone
    vecs.push_back(mk(1, 1, 32'h11110001, 1, 2, 32'h22220002, 0, 0, 1, 0)); // 3 both -> ALU
    vecs.push_back(mk(1, 1, 32'h11110001, 1, 2, 32'h22220002, 0, 0, 0, 1)); // 4 both -> LSU
    vecs.push_back(mk(1, 1, 32'h11110001, 1, 2, 32'h22220002, 0, 0, 1, 0)); // 5 both -> ALU
    vecs.push_back(mk(0, 0, 0,            1, 2, 32'h22220002, 0, 0, 0, 1)); // 6 LSU remainder
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0)); // 7 idle
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 7, 0, 0)); // 8 issue x7
    vecs.push_back(mk(0, 0, 0,            1, 7, 32'h00000077, 0, 0, 0, 1)); // 9 LSU writes x7
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0)); // 10 x7 clears
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 3, 0, 0)); // 11 issue x3
    vecs.push_back(mk(0, 0, 0,            1, 3, 32'h00000033, 0, 0, 0, 1)); // 12 LSU writes x3
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 3, 0, 0)); // 13 re-issue x3 on clear
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0)); // 14 x3 stays busy
    vecs.push_back(mk(1, 0, 32'h00001234, 0, 0, 0,            1, 0, 1, 0)); // 15 ALU x0, issue x0
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0)); // 16 idle

    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf_we",     64'(rf_we),     64'd0);
    chk("reset_rf_a3",     64'(rf_a3),     64'd0);
    chk("reset_rf_wd",     64'(rf_wd),     64'd0);
    chk("reset_busy",      64'(busy),      64'd0);
    chk("reset_alu_ready", 64'(alu_ready), 64'd0);
    chk("reset_lsu_ready", 64'(lsu_ready), 64'd0);
    rst_n = 1'b1;

    // Pair 3/4 grant ALU then LSU; vector 5 re-grants ALU, 6 finishes the LSU request
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end
    chk("x3_still_busy", 64'(busy[3]), 64'd1);
    chk("x0_never_busy", 64'(busy[0]), 64'd0);

    // Reset with a write pending in the output stage and a busy register
    run_vec(mk(1, 9, 32'h99999999, 0, 0, 0, 1, 9, 1, 0), "pend_x9");
    chk("pend_rf_we", 64'(rf_we), 64'd1);
    idle_inputs();
    async_reset_check("rst_pending");

    // Contention after reset: ALU preferred, LSU stalls 3 times across 3 ALU grants
    run_vec(mk(1, 10, 32'h0000000A, 1, 11, 32'h0000000B, 1, 12, 1, 0), "st0");
    run_vec(mk(1, 10, 32'h0000000A, 1, 11, 32'h0000000B, 0, 0,  0, 1), "st1");
    run_vec(mk(1, 10, 32'h0000000A, 1, 11, 32'h0000000B, 0, 0,  1, 0), "st2");
    run_vec(mk(1, 10, 32'h0000000A, 1, 11, 32'h0000000B, 0, 0,  0, 1), "st3");
    run_vec(mk(1, 10, 32'h0000000A, 1, 11, 32'h0000000B, 0, 0,  1, 0), "st4");
`ifdef RF_WB_STATS_EN
    chk("stats_lsu_stall_3", 64'(lsu_stall_cnt), 64'd3);
    chk("stats_alu_stall_2", 64'(alu_stall_cnt), 64'd2);
`endif
    chk("st_busy12", 64'(busy[12]), 64'd1);
    chk("st_rf_we",  64'(rf_we),    64'd1);
    // Mid-transfer reset: LSU is being granted when rst_n drops
    lsu_valid = 1; lsu_rd = 5'd11; lsu_data = 32'h0000000B;
    alu_valid = 1; alu_rd = 5'd10; alu_data = 32'h0000000A;
    async_reset_check("rst_midxfer");

    run_vec(mk(1, 4, 32'hCAFEF00D, 1, 6, 32'h0BADBEEF, 0, 0, 1, 0), "post_rst");
    run_vec(mk(0, 0, 0,            1, 6, 32'h0BADBEEF, 0, 0, 0, 1), "post_rst2");
    run_vec(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0), "post_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rf_wb_arbiter
`default_nettype wire

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the register file's single write port (we3/a3/wd3) between two writeback requesters, ALU and LSU, using valid/ready handshakes and round-robin arbitration. It also keeps a 32-entry busy scoreboard of registers with outstanding writes, which the decode/hazard logic uses for stalling. It sits between the execute/memory stages and reg_file; its outputs drive we3/a3/wd3 directly.

Parameters:
WIDTH, 32, data width of registers and write data
CNT_W, 16, width of conflict counters (only used with RF_WB_STATS_EN)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU writeback request
alu_rd  input  5  ALU destination register
alu_data  input  WIDTH  ALU result
alu_ready  output  1  ALU request accepted this cycle
lsu_valid  input  1  LSU writeback request
lsu_rd  input  5  LSU destination register
lsu_data  input  WIDTH  load data
lsu_ready  output  1  LSU request accepted this cycle
iss_valid  input  1  instruction with destination issued
iss_rd  input  5  destination of issued instruction
busy  output  32  scoreboard; bit n=1 means a write to xn is outstanding
rf_we  output  1  to reg_file we3
rf_a3  output  5  to reg_file a3
rf_wd  output  WIDTH  to reg_file wd3

Behaviour:
- Reset (async, rst_n=0): rf_we=0, rf_a3=0, rf_wd=0, busy=0, RR pointer=ALU-preferred, counters=0. Ready outputs are combinational and therefore 0 while no request is valid.
- Handshake: a transfer occurs on a rising clk edge where valid&ready=1. The requester holds rd/data stable while valid=1 and ready=0, and may not drop valid before ready.
- Arbitration (combinational grant): only one valid -> that requester is granted. Both valid -> the requester not granted last time wins; the pointer updates only on a transfer. At most one ready per cycle. A waiting requester is granted within 2 cycles.
- Write port is a registered output stage with 1-cycle latency. A transfer at edge N gives rf_we=1, rf_a3=rd, rf_wd=data during cycle N+1. The write commits in reg_file at edge N+1. With no transfer, rf_we=0 next cycle and rf_a3/rf_wd hold their previous values.
- x0: a request with rd=0 is accepted normally, but rf_we stays 0. iss_rd=0 never sets busy[0]; busy[0] is constant 0.
- Scoreboard:
  - iss_valid sets busy[iss_rd] at the next edge.
  - The cycle in which rf_we=1 for register r clears busy[r] at the following edge.
  - A same-edge set and clear of the same register: set wins, because a new producer is outstanding.
  - A set of a register already busy leaves it 1. Only one outstanding producer per register is supported; hazard logic must not issue a second one.
- Back-to-back: consecutive transfers every cycle are allowed, giving rf_we=1 on consecutive cycles. Throughput is 1 write/cycle.
- Reset mid-operation clears the output stage, so a pending write is lost, and clears busy.

Optional Feature:
RF_WB_STATS_EN: when defined, the block adds outputs alu_stall_cnt and lsu_stall_cnt (CNT_W each).
- Each counter increments when its requester has valid=1 and ready=0.
- Counters saturate at all-ones and reset to 0.
When not defined, these ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package rf_pkg holds REG_ADDR_W=5, NREG=32, requester id constants REQ_ALU=0 and REQ_LSU=1, and the default WIDTH.
- Sub-module rr_arb2 is a 2-input round-robin arbiter with pointer register. Its inputs are req[1:0] and accept; its output is a one-hot gnt[1:0].
- The top level contains the output stage and the scoreboard.

Test Plan:
1. Reset, then ALU valid with rd=5, data=0xDEADBEEF and lsu idle -> alu_ready=1 the same cycle; next cycle rf_we=1, rf_a3=5, rf_wd=0xDEADBEEF; the cycle after, rf_we=0.
2. Both valid every cycle (ALU rd=1, LSU rd=2) for 4 transfers -> grants alternate ALU, LSU, ALU, LSU; rf_a3 sequence is 1, 2, 1, 2 on consecutive cycles.
3. iss_valid with iss_rd=7 -> busy[7]=1 next cycle; LSU writes rd=7 -> busy[7] returns to 0 one edge after rf_we=1 with rf_a3=7.
4. Same edge: iss_rd=3 sets while an outstanding write to x3 is in its rf_we cycle -> busy[3] stays 1.
5. ALU rd=0, data=0x1234 -> alu_ready=1, rf_we stays 0; iss_rd=0 -> busy stays 0.
6. RF_WB_STATS_EN with LSU held valid while ALU is granted 3 times, then rst_n pulsed low mid-transfer -> lsu_stall_cnt=3 before reset; after reset, counters=0, busy=0, rf_we=0 immediately.
